// File: rtl/regfile_ctrl_pkg.sv
// Shared constants and write-request payload for the register-file control blocks.
package regfile_ctrl_pkg;

  localparam int unsigned RF_ADDR_W = 5;
  localparam int unsigned RF_DATA_W = 32;
  localparam int unsigned WB_CNT_W  = 16;

  localparam int unsigned REQ_ALU = 0;
  localparam int unsigned REQ_LSU = 1;

  typedef struct packed {
    logic [RF_ADDR_W-1:0] addr;
    logic [RF_DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter; the preference pointer moves to the losing
// side only when the caller signals that the granted transfer was taken.
module rr_arbiter2 (
  input  logic clk,
  input  logic rst,
  input  logic req0,
  input  logic req1,
  input  logic advance,
  output logic grant0,
  output logic grant1,
  output logic ptr
);

  logic ptr_q;
  logic win0;

  always_comb begin
    win0   = 1'b0;
    grant0 = 1'b0;
    grant1 = 1'b0;
    win0   = req0 && (!req1 || !ptr_q);
    grant0 = win0;
    grant1 = req1 && !win0;
  end

  // grant0 high means requester 1 lost, so it becomes preferred next
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= 1'b0;
    end else if (advance) begin
      ptr_q <= grant0;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: round-robin ALU/LSU grant, x0 filtering and a
// one-entry write stage. Macro RF_BYPASS_EN adds same-cycle write-to-read bypass.
module regfile_wb_arbiter
  import regfile_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = RF_ADDR_W,
  parameter int unsigned DATA_W = RF_DATA_W
) (
  input  logic                clk,
  input  logic                rst,

  input  logic                req0_valid,
  input  logic [ADDR_W-1:0]   req0_addr,
  input  logic [DATA_W-1:0]   req0_data,
  output logic                req0_ready,

  input  logic                req1_valid,
  input  logic [ADDR_W-1:0]   req1_addr,
  input  logic [DATA_W-1:0]   req1_data,
  output logic                req1_ready,

  input  logic                wb_stall,

  output logic                WE3,
  output logic [ADDR_W-1:0]   A3,
  output logic [DATA_W-1:0]   WD3,

  output logic                busy,
  output logic [WB_CNT_W-1:0] wr_count,

  input  logic [ADDR_W-1:0]   A1,
  input  logic [ADDR_W-1:0]   A2,
  input  logic [DATA_W-1:0]   RD1_in,
  input  logic [DATA_W-1:0]   RD2_in,
  output logic [DATA_W-1:0]   RD1,
  output logic [DATA_W-1:0]   RD2
);

  wb_req_t             alu_req;
  wb_req_t             lsu_req;
  wb_req_t             win;
  logic                grant0;
  logic                grant1;
  logic                rr_ptr_unused;
  logic                can_accept;
  logic                accept;
  logic                load;
  logic                retire;

  logic                out_valid;
  logic [ADDR_W-1:0]   out_addr;
  logic [DATA_W-1:0]   out_data;
  logic [WB_CNT_W-1:0] cnt_q;

  rr_arbiter2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req0    (req0_valid),
    .req1    (req1_valid),
    .advance (load),
    .grant0  (grant0),
    .grant1  (grant1),
    .ptr     (rr_ptr_unused)
  );

  // Handshake and winner selection; x0 writes complete but never load the stage
  always_comb begin
    alu_req    = '0;
    lsu_req    = '0;
    win        = '0;
    can_accept = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    accept     = 1'b0;
    load       = 1'b0;
    retire     = 1'b0;

    alu_req.addr = RF_ADDR_W'(req0_addr);
    alu_req.data = RF_DATA_W'(req0_data);
    lsu_req.addr = RF_ADDR_W'(req1_addr);
    lsu_req.data = RF_DATA_W'(req1_data);

    retire     = out_valid && !wb_stall;
    can_accept = !out_valid || !wb_stall;
    req0_ready = !rst && grant0 && can_accept;
    req1_ready = !rst && grant1 && can_accept;
    accept     = req0_ready || req1_ready;
    win        = grant1 ? lsu_req : alu_req;
    load       = accept && (win.addr != '0);
  end

  // One-entry output stage; a simultaneous retire and load is a straight handoff
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_addr  <= ADDR_W'(win.addr);
      out_data  <= DATA_W'(win.data);
    end else if (retire) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (retire) begin
      cnt_q <= cnt_q + WB_CNT_W'(1);
    end
  end

  assign WE3      = retire && !rst;
  assign A3       = out_addr;
  assign WD3      = out_data;
  assign busy     = out_valid;
  assign wr_count = cnt_q;

`ifdef RF_BYPASS_EN
  // A write retiring this cycle is forwarded to matching reads (x0 always reads raw)
  always_comb begin
    RD1 = RD1_in;
    RD2 = RD2_in;
    if (WE3 && (A3 == A1) && (A1 != '0)) begin
      RD1 = WD3;
    end
    if (WE3 && (A3 == A2) && (A2 != '0)) begin
      RD2 = WD3;
    end
  end
`else
  logic addr_unused;

  assign addr_unused = ^{A1, A2};
  assign RD1         = RD1_in;
  assign RD2         = RD2_in;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: expected writes are queued on accept
// and compared in order when WE3 fires; readies come from a small reference model.
module tb_regfile_wb_arbiter;
  import regfile_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0;
  logic [4:0]  req0_addr = '0;
  logic [31:0] req0_data = '0;
  logic        req0_ready;
  logic        req1_valid = 1'b0;
  logic [4:0]  req1_addr = '0;
  logic [31:0] req1_data = '0;
  logic        req1_ready;
  logic        wb_stall = 1'b0;
  logic        WE3;
  logic [4:0]  A3;
  logic [31:0] WD3;
  logic        busy;
  logic [15:0] wr_count;
  logic [4:0]  A1 = '0;
  logic [4:0]  A2 = '0;
  logic [31:0] RD1_in = '0;
  logic [31:0] RD2_in = '0;
  logic [31:0] RD1;
  logic [31:0] RD2;

  int total = 0;
  int bad   = 0;

  wb_req_t     sb_q[$];
  logic        m_out_valid = 1'b0;
  logic        m_ptr = 1'b0;
  int unsigned m_count = 0;
  logic        e_r0 = 1'b0;
  logic        e_r1 = 1'b0;

  regfile_wb_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_addr  (req0_addr),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_addr  (req1_addr),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .wb_stall   (wb_stall),
    .WE3        (WE3),
    .A3         (A3),
    .WD3        (WD3),
    .busy       (busy),
    .wr_count   (wr_count),
    .A1         (A1),
    .A2         (A2),
    .RD1_in     (RD1_in),
    .RD2_in     (RD2_in),
    .RD1        (RD1),
    .RD2        (RD2)
  );

  always #5 clk = ~clk;

  // Requesters must keep their payload stable until ready
  logic        pv0 = 1'b0, pr0 = 1'b0, pv1 = 1'b0, pr1 = 1'b0;
  logic [36:0] pp0 = '0, pp1 = '0;
  always @(negedge clk) begin
    if (!rst && pv0 && !pr0 && req0_valid)
      assert ({req0_addr, req0_data} == pp0) else $error("req0 payload changed before ready");
    if (!rst && pv1 && !pr1 && req1_valid)
      assert ({req1_addr, req1_data} == pp1) else $error("req1 payload changed before ready");
    pv0 <= req0_valid && !rst;
    pr0 <= req0_ready;
    pp0 <= {req0_addr, req0_data};
    pv1 <= req1_valid && !rst;
    pr1 <= req1_ready;
    pp1 <= {req1_addr, req1_data};
  end

  // Mid-cycle: update model expectations and retire the scoreboard head on WE3
  task automatic sample();
    logic    exp_we;
    logic    g0;
    logic    can;
    wb_req_t exp;
    @(negedge clk);
    #1;
    exp_we = 1'b0;
    if (rst) begin
      e_r0 = 1'b0;
      e_r1 = 1'b0;
      m_out_valid = 1'b0;
      m_ptr = 1'b0;
      m_count = 0;
      sb_q.delete();
    end else begin
      can    = !m_out_valid || !wb_stall;
      g0     = req0_valid && (!req1_valid || !m_ptr);
      e_r0   = g0 && can;
      e_r1   = req1_valid && !g0 && can;
      exp_we = m_out_valid && !wb_stall;
    end
    total++;
    if (WE3 !== exp_we) begin
      bad++;
      $display("FAIL we3 got=%b want=%b at %0t", WE3, exp_we, $time);
    end
    if (exp_we && sb_q.size() > 0) begin
      exp = sb_q.pop_front();
      m_count++;
      total++;
      if (A3 !== exp.addr || WD3 !== exp.data) begin
        bad++;
        $display("FAIL sb_write got A3=%0d WD3=%h want A3=%0d WD3=%h", A3, WD3, exp.addr, exp.data);
      end
    end
  endtask

  // Clock edge: push accepted non-x0 writes and advance the model
  task automatic advance();
    logic ld;
    @(posedge clk);
    ld = 1'b0;
    if (!rst) begin
      if (req0_valid && e_r0) begin
        if (req0_addr != 5'd0) begin
          sb_q.push_back('{addr: req0_addr, data: req0_data});
          m_ptr = 1'b1;
          ld = 1'b1;
        end
      end else if (req1_valid && e_r1) begin
        if (req1_addr != 5'd0) begin
          sb_q.push_back('{addr: req1_addr, data: req1_data});
          m_ptr = 1'b0;
          ld = 1'b1;
        end
      end
      if (ld) m_out_valid = 1'b1;
      else if (m_out_valid && !wb_stall) m_out_valid = 1'b0;
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wb_stall = 1'b0;
    sample();
    advance();
    rst = 1'b0;
  endtask

  task automatic drain(input int n);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      sample();
      advance();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req0_valid = 1'b1; req0_addr = 5'd4; req0_data = 32'h44;
    req1_valid = 1'b1; req1_addr = 5'd8; req1_data = 32'h88;
    advance();
    sample();
    total++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      bad++; $display("FAIL reset_ready got=%b want=00", {req0_ready, req1_ready});
    end
    total++;
    if ({busy, wr_count, A3, WD3} !== '0) begin
      bad++; $display("FAIL reset_state got busy=%b cnt=%0d A3=%0d WD3=%h want all 0", busy, wr_count, A3, WD3);
    end
    advance();
    rst = 1'b0;
    drain(1);
  endtask

  task automatic test_single();
    do_reset();
    req0_valid = 1'b1; req0_addr = 5'd9; req0_data = 32'h20;
    sample();
    total++;
    if ({req0_ready, req1_ready} !== {e_r0, e_r1}) begin
      bad++; $display("FAIL single_ready got=%b want=%b", {req0_ready, req1_ready}, {e_r0, e_r1});
    end
    advance();
    drain(2);
    total++;
    if (wr_count !== 16'(m_count) || wr_count !== 16'd1) begin
      bad++; $display("FAIL single_count got=%0d want=1", wr_count);
    end
  endtask

  task automatic test_contention();
    do_reset();
    req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'hAAAA;
    req1_valid = 1'b1; req1_addr = 5'd6; req1_data = 32'hBBBB;
    sample();
    total++;
    if ({req0_ready, req1_ready} !== 2'b10 || {e_r0, e_r1} !== 2'b10) begin
      bad++; $display("FAIL contend_first got=%b want=10", {req0_ready, req1_ready});
    end
    advance();
    req0_addr = 5'd10; req0_data = 32'h1111;
    sample();
    total++;
    if ({req0_ready, req1_ready} !== {e_r0, e_r1}) begin
      bad++; $display("FAIL contend_second got=%b want=%b", {req0_ready, req1_ready}, {e_r0, e_r1});
    end
    advance();
    req1_valid = 1'b0;
    sample();
    total++;
    if ({req0_ready, req1_ready} !== {e_r0, e_r1}) begin
      bad++; $display("FAIL contend_third got=%b want=%b", {req0_ready, req1_ready}, {e_r0, e_r1});
    end
    advance();
    drain(2);
    total++;
    if (sb_q.size() != 0 || wr_count !== 16'd3) begin
      bad++; $display("FAIL contend_drain got pending=%0d cnt=%0d want 0 and 3", sb_q.size(), wr_count);
    end
  endtask

  task automatic test_x0();
    do_reset();
    req1_valid = 1'b1; req1_addr = 5'd0; req1_data = 32'hFFFF;
    sample();
    total++;
    if ({req0_ready, req1_ready} !== 2'b01) begin
      bad++; $display("FAIL x0_lsu_ready got=%b want=01", {req0_ready, req1_ready});
    end
    advance();
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_addr = 5'd0; req0_data = 32'hEEEE;
    sample();
    total++;
    if ({req0_ready, req1_ready, busy} !== 3'b100) begin
      bad++; $display("FAIL x0_alu got ready/busy=%b want=100", {req0_ready, req1_ready, busy});
    end
    advance();
    req0_addr = 5'd1; req0_data = 32'hA1;
    req1_valid = 1'b1; req1_addr = 5'd2; req1_data = 32'hB2;
    sample();
    total++;
    if ({req0_ready, req1_ready, busy} !== 3'b100 || wr_count !== 16'd0) begin
      bad++; $display("FAIL x0_ptr_kept got ready/busy=%b cnt=%0d want=100 cnt 0",
                      {req0_ready, req1_ready, busy}, wr_count);
    end
    advance();
    req0_valid = 1'b0;
    sample();
    advance();
    drain(2);
    total++;
    if (sb_q.size() != 0 || wr_count !== 16'd2) begin
      bad++; $display("FAIL x0_drain got pending=%0d cnt=%0d want 0 and 2", sb_q.size(), wr_count);
    end
  endtask

  task automatic test_stall();
    do_reset();
    req0_valid = 1'b1; req0_addr = 5'd12; req0_data = 32'hC0DE;
    sample();
    advance();
    wb_stall = 1'b1;
    req0_addr = 5'd13; req0_data = 32'h1313;
    req1_valid = 1'b1; req1_addr = 5'd14; req1_data = 32'h1414;
    for (int i = 0; i < 3; i++) begin
      sample();
      total++;
      if ({req0_ready, req1_ready} !== 2'b00 || A3 !== 5'd12 || WD3 !== 32'hC0DE || busy !== 1'b1) begin
        bad++; $display("FAIL stall_hold%0d got ready=%b A3=%0d WD3=%h busy=%b want 00 12 c0de 1",
                        i, {req0_ready, req1_ready}, A3, WD3, busy);
      end
      advance();
    end
    wb_stall = 1'b0;
    sample();
    total++;
    if ({req0_ready, req1_ready} !== 2'b01) begin
      bad++; $display("FAIL stall_release got=%b want=01", {req0_ready, req1_ready});
    end
    advance();
    req1_valid = 1'b0;
    sample();
    advance();
    drain(2);
    total++;
    if (sb_q.size() != 0 || wr_count !== 16'd3) begin
      bad++; $display("FAIL stall_drain got pending=%0d cnt=%0d want 0 and 3", sb_q.size(), wr_count);
    end
    wb_stall = 1'b1;
    req0_valid = 1'b1; req0_addr = 5'd15; req0_data = 32'h1515;
    sample();
    total++;
    if (req0_ready !== 1'b1) begin
      bad++; $display("FAIL stall_absorb got=%b want=1", req0_ready);
    end
    advance();
    req0_addr = 5'd16; req0_data = 32'h1616;
    sample();
    total++;
    if (req0_ready !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL stall_full got ready=%b busy=%b want 0 1", req0_ready, busy);
    end
    advance();
    wb_stall = 1'b0;
    sample();
    advance();
    drain(2);
    total++;
    if (sb_q.size() != 0 || wr_count !== 16'd5) begin
      bad++; $display("FAIL stall_absorb_drain got pending=%0d cnt=%0d want 0 and 5", sb_q.size(), wr_count);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req0_valid = 1'b1; req0_addr = 5'd20; req0_data = 32'h77;
    sample();
    advance();
    rst = 1'b1;
    req0_addr = 5'd21; req0_data = 32'h2121;
    req1_valid = 1'b1; req1_addr = 5'd22; req1_data = 32'h2222;
    sample();
    total++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      bad++; $display("FAIL rstmid_ready got=%b want=00", {req0_ready, req1_ready});
    end
    advance();
    rst = 1'b0;
    sample();
    total++;
    if ({req0_ready, req1_ready, busy} !== 3'b100 || wr_count !== 16'd0) begin
      bad++; $display("FAIL rstmid_after got ready/busy=%b cnt=%0d want=100 cnt 0",
                      {req0_ready, req1_ready, busy}, wr_count);
    end
    advance();
    req0_valid = 1'b0;
    sample();
    advance();
    drain(2);
    total++;
    if (sb_q.size() != 0 || wr_count !== 16'd2) begin
      bad++; $display("FAIL rstmid_drain got pending=%0d cnt=%0d want 0 and 2", sb_q.size(), wr_count);
    end
  endtask

  task automatic test_bypass();
    logic [31:0] exp1;
    logic [31:0] exp2;
    do_reset();
    A1 = 5'd7; RD1_in = 32'h0; A2 = 5'd7; RD2_in = 32'h5555;
    req0_valid = 1'b1; req0_addr = 5'd7; req0_data = 32'h1234;
    sample();
    total++;
    if (RD1 !== 32'h0 || RD2 !== 32'h5555) begin
      bad++; $display("FAIL bypass_idle got RD1=%h RD2=%h want 0 5555", RD1, RD2);
    end
    advance();
    req0_data = 32'h4321;
    A1 = 5'd0; RD1_in = 32'h99;
`ifdef RF_BYPASS_EN
    exp2 = 32'h1234;
`else
    exp2 = 32'h5555;
`endif
    exp1 = 32'h99;
    sample();
    total++;
    if (RD1 !== exp1 || RD2 !== exp2) begin
      bad++; $display("FAIL bypass_x0_a1 got RD1=%h RD2=%h want %h %h", RD1, RD2, exp1, exp2);
    end
    advance();
    req0_valid = 1'b0;
    A1 = 5'd7; RD1_in = 32'h0;
`ifdef RF_BYPASS_EN
    exp1 = 32'h4321;
`else
    exp1 = 32'h0;
`endif
    sample();
    total++;
    if (RD1 !== exp1) begin
      bad++; $display("FAIL bypass_rd1 got=%h want=%h", RD1, exp1);
    end
    advance();
    drain(1);
  endtask

  task automatic test_back_to_back();
    do_reset();
    req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'h1;
    req1_valid = 1'b1; req1_addr = 5'd3; req1_data = 32'h2;
    sample();
    advance();
    req0_valid = 1'b0;
    sample();
    advance();
    req1_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req0_valid = 1'b1;
      req0_addr  = 5'(16 + i);
      req0_data  = 32'(i * 32'h11);
      sample();
      total++;
      if (req0_ready !== 1'b1 || e_r0 !== 1'b1) begin
        bad++; $display("FAIL stream%0d got ready=%b want=1", i, req0_ready);
      end
      advance();
    end
    drain(2);
    total++;
    if (sb_q.size() != 0 || wr_count !== 16'd6) begin
      bad++; $display("FAIL b2b_drain got pending=%0d cnt=%0d want 0 and 6", sb_q.size(), wr_count);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_x0();
    test_stall();
    test_reset_mid();
    test_bypass();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter and sequencer for the 32×32 register file's single write port (WE3/A3/WD3). Two requesters share the port through valid/ready handshakes: requester 0 is the ALU result and requester 1 is the load-data return. The block grants round-robin, drops writes to x0, and registers the winning write into a one-entry output stage that drives the register file. It sits between the execute/memory stages and the register file in the non-pipelined core.

## Interface
- ADDR_W, 5, register address width
- DATA_W, 32, register data width
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- req0_valid  in  1  ALU write request
- req0_addr  in  ADDR_W  ALU destination register
- req0_data  in  DATA_W  ALU result
- req0_ready  out  1  ALU request accepted this cycle
- req1_valid, req1_addr, req1_data, req1_ready: same as req0, for the load path
- wb_stall  in  1  hold the output stage; no register-file write this cycle
- WE3  out  1  register-file write enable
- A3  out  ADDR_W  register-file write address
- WD3  out  DATA_W  register-file write data
- busy  out  1  output stage holds a write not yet retired
- wr_count  out  16  retired-write counter; wraps at 16 bits
- A1, A2  in  ADDR_W  register-file read addresses (bypass, see Configuration)
- RD1_in, RD2_in  in  DATA_W  raw register-file read data
- RD1, RD2  out  DATA_W  read data after the optional bypass

## Operation
- Output stage is one entry: out_valid, out_addr, out_data.
- The stage retires when out_valid && !wb_stall.
- WE3 = out_valid && !wb_stall; A3 = out_addr; WD3 = out_data.
- Stage can accept when !out_valid || !wb_stall, which gives a full-throughput handoff.
- Arbitration:
  - rr_ptr names the preferred requester.
  - If both requests are valid, the preferred one wins; otherwise the single valid one wins.
  - reqN_ready = grantN && stage can accept. It is combinational and may depend on valid; requesters must not wait for ready before asserting valid.
- On accept, rr_ptr becomes the non-winner. rr_ptr changes only on an accepted transfer.
- x0 writes: an accepted request with addr==0 completes the handshake but does not load the stage (out_valid stays or goes 0 per retirement). It does not increment wr_count and does not move rr_ptr.
- wr_count increments by 1 on every retirement (WE3 high).
- busy = out_valid.
- Back-to-back writes to the same register from both requesters retire in grant order; the later grant wins in the register file.
- Requesters must hold valid/addr/data stable until ready. A changed payload before ready is a protocol violation; behaviour is undefined (assertion in the bench).

## Timing
- Latency: accept in cycle N → WE3 high in cycle N+1 (if wb_stall is low in N+1). The register file is updated at the end of N+1.
- Sustained throughput: one write per cycle when wb_stall is low.
- While wb_stall is high:
  - the stage holds its contents and WE3 = 0;
  - ready is low if the stage is full, and high if the stage is empty (one write can be absorbed).
- Reset (any cycle, including mid-transfer):
  - out_valid, out_addr, out_data clear to 0;
  - rr_ptr = 0 (ALU preferred);
  - wr_count = 0;
  - WE3 = 0 and both readies = 0 during the reset cycle;
  - an in-flight write is discarded.
- Reset has priority over wb_stall and all requests.

## Configuration
- RF_BYPASS_EN defined:
  - RD1 = WD3 when WE3 && A3==A1 && A1!=0, else RD1_in;
  - RD2 is the same using A2.
  - Effect: a write retiring this cycle is visible to same-cycle reads.
- RF_BYPASS_EN undefined: RD1 = RD1_in and RD2 = RD2_in (pure pass-through, no comparators).

## Structure
- Package regfile_ctrl_pkg:
  - constants RF_ADDR_W=5, RF_DATA_W=32, REQ_ALU=0, REQ_LSU=1;
  - typedef wb_req_t {addr, data}.
- Sub-module rr_arbiter2: two-input round-robin grant with a pointer-update-on-accept input. It is reusable for the memory-port arbiter.
- Output stage, x0 filter, counter and bypass live in the top module.

## Test plan
- Single ALU write: req0 addr=9, data=0x20 → req0_ready in cycle 0; WE3=1, A3=9, WD3=0x20 in cycle 1; wr_count=1.
- Simultaneous requests after reset: req0 (5, 0xAAAA), req1 (6, 0xBBBB) both held → ALU retires first, then LSU; a second contention round grants LSU first.
- x0 drop: req1 addr=0, data=0xFFFF → ready=1, WE3 never asserts, wr_count unchanged, rr_ptr unchanged.
- Stall: full stage with wb_stall high for 3 cycles → WE3=0, both readies 0, A3/WD3 stable; write retires in the cycle stall drops.
- Reset mid-operation: rst pulsed while a write is staged → no WE3 after reset, wr_count=0, next contention grants ALU.
- Bypass (RF_BYPASS_EN): WE3 to reg 7 = 0x1234 with A1=7, RD1_in=0 → RD1=0x1234. Same stimulus with A1=0 → RD1=RD1_in. Without the macro → RD1=RD1_in.
